// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational ALU between NUM_REQ requesters.
// One op in flight; results return with the requester ID over a valid/ready handshake.
module alu_rr_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned EXEC_CYCLES = 1,
    localparam int unsigned IDW        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [3*NUM_REQ-1:0]  req_opcode,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [15:0]           alu_inputA,
    output logic [15:0]           alu_inputB,
    output logic [2:0]            alu_opcode,
    input  logic [31:0]           alu_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [31:0]           resp_result,
    output logic                  resp_err,
    output logic                  busy,
    output logic [15:0]           op_count
);

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 3;
    localparam int unsigned CW  = 4;
    localparam logic [OPW-1:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      rr_next;
    logic [CW-1:0]       wait_cnt;
    logic [IDW-1:0]      win;
    logic                win_found;
    int unsigned         idx;
    logic                accept;
    logic                handshake;
    logic                illegal;
    logic [OPW-1:0]      op_arr [NUM_REQ];
    logic [DW-1:0]       a_arr  [NUM_REQ];
    logic [DW-1:0]       b_arr  [NUM_REQ];
    logic [OPW-1:0]      sel_op;
    logic [DW-1:0]       sel_a;
    logic [DW-1:0]       sel_b;

    // Unpack the flat request buses into per-requester fields.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_opcode[g*OPW +: OPW];
        assign a_arr[g]  = req_a[g*DW +: DW];
        assign b_arr[g]  = req_b[g*DW +: DW];
    end

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin : arb
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && req_valid[IDW'(idx)]) begin
                win_found = 1'b1;
                win       = IDW'(idx);
            end
        end
    end

    assign sel_op    = op_arr[win];
    assign sel_a     = a_arr[win];
    assign sel_b     = b_arr[win];
    assign illegal   = (sel_op == OP_ILLEGAL);
    assign rr_next   = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
    // Grant is combinational but forced off while reset is asserted.
    assign req_ready = (rst_n && (state == IDLE) && win_found) ? (NUM_REQ'(1) << win) : '0;
    assign accept    = |(req_valid & req_ready);
    assign handshake = resp_valid && resp_ready;

    always_comb begin : fsm_next
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = illegal ? RESP : EXEC;
            EXEC: if (wait_cnt == '0) state_next = RESP;
            RESP: if (handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            alu_inputA  <= '0;
            alu_inputB  <= '0;
            alu_opcode  <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            busy        <= 1'b0;
            op_count    <= '0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != IDLE);
            resp_valid <= (state_next == RESP);
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr   <= rr_next;
                        resp_id  <= win;
                        wait_cnt <= CW'(EXEC_CYCLES - 1);
                        // Illegal opcodes never reach the ALU; answer with an error at once.
                        if (illegal) begin
                            resp_result <= '0;
                            resp_err    <= 1'b1;
                        end else begin
                            alu_opcode <= sel_op;
                            alu_inputA <= sel_a;
                            alu_inputB <= sel_b;
                        end
                    end
                end
                EXEC: begin
                    if (wait_cnt == '0) begin
                        resp_result <= alu_result;
                        resp_err    <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (handshake) begin
                        op_count <= op_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
